// File: rtl/bus_memory_responder.sv
// rtl/bus_memory_responder.sv - 2**AW x DW synchronous memory responder with programmable read latency
// Optional write protection of addresses below PROT_TOP: define MEM_WRPROT_EN.
module bus_memory_responder #(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int READ_LAT = 1,
    parameter int PROT_TOP = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          rd,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          rdata_vld,
    output logic          ready,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_HOLD,
        WR_HOLD
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [DW-1:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   rd_sel;
    logic [2:0]      cnt;
    logic            mem_we;
    logic            rd_load;
    logic            cnt_load;
    logic            err_n;
    logic            prot_hit;

`ifdef MEM_WRPROT_EN
    assign prot_hit = (int'(addr) < PROT_TOP);
`else
    assign prot_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        mem_we   = 1'b0;
        rd_load  = 1'b0;
        rd_sel   = addr_q;
        cnt_load = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (rd && wr) begin
                    err_n = 1'b1;
                end else if (rd) begin
                    cnt_load = 1'b1;
                    if (READ_LAT == 0) begin
                        rd_load = 1'b1;
                        rd_sel  = addr;
                        state_n = RD_HOLD;
                    end else begin
                        state_n = RD_WAIT;
                    end
                end else if (wr) begin
                    // A protected write still occupies the bus; only the array update is suppressed.
                    mem_we  = !prot_hit;
                    err_n   = prot_hit;
                    state_n = WR_HOLD;
                end
            end
            RD_WAIT: begin
                if (!rd) begin
                    state_n = IDLE;
                end else if (cnt == 3'd1) begin
                    rd_load = 1'b1;
                    state_n = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (!rd) begin
                    state_n = IDLE;
                end
            end
            WR_HOLD: begin
                err_n = rd;
                if (!wr) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The array has no reset; a write racing a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata     <= '0;
            rdata_vld <= 1'b0;
            err       <= 1'b0;
            cnt       <= 3'd0;
            addr_q    <= '0;
        end else begin
            err <= err_n;
            if (cnt_load) begin
                addr_q <= addr;
                cnt    <= 3'(READ_LAT);
            end else if (state == RD_WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (rd_load) begin
                rdata     <= mem[rd_sel];
                rdata_vld <= 1'b1;
            end else if (state_n != RD_HOLD) begin
                rdata_vld <= 1'b0;
            end
        end
    end

    assign ready = (state != RD_WAIT);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_bus_memory_responder.sv
// tb/tb_bus_memory_responder.sv - randomized bench for bus_memory_responder at latencies 0, 1, 3 and 7
module tb_bus_memory_responder;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] addr = '0;
    logic       rd = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wdata = '0;

    logic [7:0] rdata_o [N];
    logic       vld_o   [N];
    logic       ready_o [N];
    logic       busy_o  [N];
    logic       err_o   [N];

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m   [32];
    logic [7:0] last_rd [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        bus_memory_responder #(
            .AW(5),
            .DW(8),
            .READ_LAT(g == 0 ? 0 : g == 1 ? 1 : g == 2 ? 3 : 7),
            .PROT_TOP(8)
        ) dut (
            .clk(clk),
            .rst(rst),
            .addr(addr),
            .rd(rd),
            .wr(wr),
            .wdata(wdata),
            .rdata(rdata_o[g]),
            .rdata_vld(vld_o[g]),
            .ready(ready_o[g]),
            .busy(busy_o[g]),
            .err(err_o[g])
        );
    end

    function automatic int lat(input int g);
        case (g)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 7;
        endcase
    endfunction

    function automatic bit is_prot(input logic [4:0] a);
`ifdef MEM_WRPROT_EN
        return (a < 5'd8);
`else
        return (a != a);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string ph, input int g, input logic e_vld, input logic e_ready,
                           input logic e_busy, input logic e_err);
        string p;
        p = $sformatf("%s L%0d ", ph, lat(g));
        check({p, "rdata"}, 32'(rdata_o[g]), 32'(last_rd[g]));
        check({p, "vld"},   32'(vld_o[g]),   32'(e_vld));
        check({p, "ready"}, 32'(ready_o[g]), 32'(e_ready));
        check({p, "busy"},  32'(busy_o[g]),  32'(e_busy));
        check({p, "err"},   32'(err_o[g]),   32'(e_err));
    endtask

    task automatic do_reset();
        rst = 1'b1; rd = 1'b1; wr = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            for (int g = 0; g < N; g++) begin
                last_rd[g] = 8'h00;
                chk_out("reset", g, 1'b0, 1'b1, 1'b0, 1'b0);
            end
        end
        rst = 1'b0; rd = 1'b0; wr = 1'b0;
        tick();
    endtask

    // wr held for h edges; optional rd pulse on hold edge rd_at (>=1), with random bus noise after acceptance.
    task automatic do_write(input logic [4:0] a, input logic [7:0] d, input int h, input int rd_at);
        bit prot;
        prot = is_prot(a);
        addr = a; wdata = d; wr = 1'b1;
        for (int k = 0; k < h; k++) begin
            rd = (k == rd_at);
            tick();
            if (k == 0 && !prot) mem_m[a] = d;
            for (int g = 0; g < N; g++)
                chk_out("write", g, 1'b0, 1'b1, 1'b1, (k == 0 && prot) || (k == rd_at && k >= 1));
            addr = 5'($urandom); wdata = 8'($urandom);
        end
        wr = 1'b0; rd = 1'b0;
        tick();
        for (int g = 0; g < N; g++) chk_out("write_end", g, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // rd held for h edges; data is due l edges after acceptance unless rd drops first.
    task automatic do_read(input logic [4:0] a, input int h);
        addr = a; rd = 1'b1;
        for (int k = 0; k < h; k++) begin
            tick();
            for (int g = 0; g < N; g++) begin
                if (k == lat(g)) last_rd[g] = mem_m[a];
                chk_out("read", g, k >= lat(g), k >= lat(g), 1'b1, 1'b0);
            end
            addr = 5'($urandom);
        end
        rd = 1'b0;
        tick();
        for (int g = 0; g < N; g++) chk_out("read_end", g, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_both(input logic [4:0] a, input logic [7:0] d, input int n);
        addr = a; wdata = d; rd = 1'b1; wr = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            for (int g = 0; g < N; g++) chk_out("both", g, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        rd = 1'b0; wr = 1'b0;
        tick();
        for (int g = 0; g < N; g++) chk_out("both_end", g, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_mid_reset(input logic [4:0] a);
        addr = a; rd = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        for (int g = 0; g < N; g++) begin
            last_rd[g] = 8'h00;
            chk_out("mid_reset", g, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        rst = 1'b0; rd = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 32; i++) do_write(5'(i), 8'($urandom), 1, -1);

        do_write(5'h1A, 8'hC3, 3, -1);
        tick();
        do_read(5'h1A, 4);
        do_write(5'h11, 8'h5A, 1, -1);
        do_read(5'h11, 1);
        do_read(5'h11, 9);
        do_read(5'h11, 2);
        do_both(5'h03, 8'hFF, 2);
        do_read(5'h03, 8);
        do_write(5'h04, 8'h31, 3, 1);
        do_write(5'h02, 8'h77, 2, -1);
        do_write(5'h08, 8'h77, 2, -1);
        do_read(5'h02, 8);
        do_read(5'h08, 8);
        do_mid_reset(5'h08);
        do_read(5'h1A, 8);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: do_write(5'($urandom), 8'($urandom), int'($urandom_range(1, 3)),
                            ($urandom_range(0, 3) == 0) ? 1 : -1);
                1, 2: do_read(5'($urandom), int'($urandom_range(1, 10)));
                default: do_both(5'($urandom), 8'($urandom), int'($urandom_range(1, 2)));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
